// File: rtl/key_cmd_pkg.sv
// Shared constants for the keypad command controller: key codes and FSM state encoding.
package key_cmd_pkg;

   localparam logic [3:0] KEY_ENTER  = 4'hA;
   localparam logic [3:0] KEY_BKSP   = 4'hB;
   localparam logic [3:0] KEY_CLR    = 4'hC;
   localparam logic [3:0] KEY_GATE   = 4'hD;
   localparam logic [3:0] KEY_RUN    = 4'hE;
   localparam logic [3:0] KEY_CANCEL = 4'hF;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PRESS   = 2'd1;
   localparam logic [1:0] ST_EXEC    = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   function automatic logic is_digit(input logic [3:0] code);
      return (code <= 4'd9);
   endfunction

endpackage

// File: rtl/key_sync_db.sv
// Two-flop synchroniser for the scanner outputs plus the stable-time counter
// that qualifies a press (PRESS state) and a release (RELEASE state).
module key_sync_db
   import key_cmd_pkg::*;
#(
   parameter int DB = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_key_valid,
   input  logic [3:0] i_key_value,
   input  logic [1:0] i_state,
   input  logic [3:0] i_code,
   output logic       o_valid_s,
   output logic [3:0] o_value_s,
   output logic       o_press_ok,
   output logic       o_release_ok
);

   localparam int             CW      = $clog2(DB + 1);
   localparam logic [CW-1:0] CNT_END = CW'(DB - 1);

   logic          r_valid_m;
   logic          r_valid_s;
   logic [3:0]    r_value_m;
   logic [3:0]    r_value_s;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_at_end;
   logic          w_same;

   assign w_at_end = (r_cnt == CNT_END);
   assign w_same   = (r_value_s == i_code);

   // Counter restarts on any disturbance and parks at zero outside PRESS/RELEASE.
   always_comb begin
      w_cnt_nxt = '0;
      case (i_state)
         ST_PRESS:   if (r_valid_s && w_same && !w_at_end) w_cnt_nxt = r_cnt + CW'(1);
         ST_RELEASE: if (!r_valid_s && !w_at_end)          w_cnt_nxt = r_cnt + CW'(1);
         default:    w_cnt_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid_m <= 1'b0;
         r_valid_s <= 1'b0;
         r_value_m <= 4'h0;
         r_value_s <= 4'h0;
         r_cnt     <= '0;
      end else begin
         r_valid_m <= i_key_valid;
         r_valid_s <= r_valid_m;
         r_value_m <= i_key_value;
         r_value_s <= r_value_m;
         r_cnt     <= w_cnt_nxt;
      end
   end

   assign o_valid_s    = r_valid_s;
   assign o_value_s    = r_value_s;
   assign o_press_ok   = (i_state == ST_PRESS) && r_valid_s && w_same && w_at_end;
   assign o_release_ok = (i_state == ST_RELEASE) && !r_valid_s && w_at_end;

endmodule

// File: rtl/key_cmd_ctrl.sv
// Keypad command controller: debounced press FSM plus BCD entry buffer,
// setpoint commit, gate-time select and run control for the cymometer core.
module key_cmd_ctrl
   import key_cmd_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int DEBOUNCE_MS = 20,
   parameter int DIGITS      = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                key_valid,
   input  logic [3:0]          key_value,
   output logic [4*DIGITS-1:0] entry_bcd,
   output logic [3:0]          entry_len,
   output logic [4*DIGITS-1:0] set_bcd,
   output logic                set_strobe,
   output logic [1:0]          gate_sel,
   output logic                run,
   output logic                key_event,
   output logic                err
);

   localparam int         DB      = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam logic [3:0] LEN_MAX = 4'(DIGITS);

   logic [1:0]          r_state;
   logic [3:0]          r_code;
   logic [4*DIGITS-1:0] r_entry;
   logic [3:0]          r_len;
   logic [4*DIGITS-1:0] r_set;
   logic                r_set_strobe;
   logic [1:0]          r_gate;
   logic                r_run;
   logic                r_key_event;
   logic                r_err;

   logic                w_valid_s;
   logic [3:0]          w_value_s;
   logic                w_press_ok;
   logic                w_release_ok;
   logic [4*DIGITS+3:0] w_entry_cat;

   key_sync_db #(.DB(DB)) u_sync_db (
      .clk          (clk),
      .reset        (reset),
      .i_key_valid  (key_valid),
      .i_key_value  (key_value),
      .i_state      (r_state),
      .i_code       (r_code),
      .o_valid_s    (w_valid_s),
      .o_value_s    (w_value_s),
      .o_press_ok   (w_press_ok),
      .o_release_ok (w_release_ok)
   );

   // New digit enters at the bottom; the oldest digit falls off the top slice.
   assign w_entry_cat = {r_entry, r_code};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_code       <= 4'h0;
         r_entry      <= '0;
         r_len        <= 4'h0;
         r_set        <= '0;
         r_set_strobe <= 1'b0;
         r_gate       <= 2'd0;
         r_run        <= 1'b0;
         r_key_event  <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_set_strobe <= 1'b0;
         r_key_event  <= 1'b0;
         r_err        <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_valid_s) begin
                  r_code  <= w_value_s;
                  r_state <= ST_PRESS;
               end
            end
            ST_PRESS: begin
               if (!w_valid_s) begin
                  r_state <= ST_IDLE;
               end else if (w_value_s != r_code) begin
                  r_code <= w_value_s;
               end else if (w_press_ok) begin
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_state     <= ST_RELEASE;
               r_key_event <= 1'b1;
               if (is_digit(r_code)) begin
                  if (r_len < LEN_MAX) begin
                     r_entry <= w_entry_cat[4*DIGITS-1:0];
                     r_len   <= r_len + 4'd1;
                  end else begin
                     r_err <= 1'b1;
                  end
               end else begin
                  case (r_code)
                     KEY_ENTER: begin
                        if (r_len != 4'd0) begin
                           r_set        <= r_entry;
                           r_set_strobe <= 1'b1;
                           r_entry      <= '0;
                           r_len        <= 4'h0;
                        end else begin
                           r_err <= 1'b1;
                        end
                     end
                     KEY_BKSP: begin
                        if (r_len != 4'd0) begin
                           r_entry <= r_entry >> 4;
                           r_len   <= r_len - 4'd1;
                        end else begin
                           r_err <= 1'b1;
                        end
                     end
                     KEY_CLR: begin
                        r_entry <= '0;
                        r_len   <= 4'h0;
                     end
                     KEY_GATE: r_gate <= r_gate + 2'd1;
                     KEY_RUN:  r_run  <= ~r_run;
                     default: begin
                        r_entry <= '0;
                        r_len   <= 4'h0;
                        r_run   <= 1'b0;
                     end
                  endcase
               end
            end
            ST_RELEASE: begin
               if (w_release_ok) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign entry_bcd  = r_entry;
   assign entry_len  = r_len;
   assign set_bcd    = r_set;
   assign set_strobe = r_set_strobe;
   assign gate_sel   = r_gate;
   assign run        = r_run;
   assign key_event  = r_key_event;
   assign err        = r_err;

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Self-checking bench for key_cmd_ctrl: directed keypad sequences plus random
// presses, compared against a digit-queue model of the command rules.
module tb_key_cmd_ctrl;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          key_valid = 1'b0;
   logic [3:0]    key_value = 4'h0;
   logic [W-1:0]  entry_bcd;
   logic [3:0]    entry_len;
   logic [W-1:0]  set_bcd;
   logic          set_strobe;
   logic [1:0]    gate_sel;
   logic          run;
   logic          key_event;
   logic          err;

   key_cmd_ctrl #(.CLK_HZ(1000), .DEBOUNCE_MS(4), .DIGITS(DIGITS)) dut (
      .clk        (clk),
      .reset      (reset),
      .key_valid  (key_valid),
      .key_value  (key_value),
      .entry_bcd  (entry_bcd),
      .entry_len  (entry_len),
      .set_bcd    (set_bcd),
      .set_strobe (set_strobe),
      .gate_sel   (gate_sel),
      .run        (run),
      .key_event  (key_event),
      .err        (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_event = 0;
   int n_err = 0;
   int n_strobe = 0;

   // Reference model: digits oldest-first, newest at the back.
   int           mq[$];
   logic [W-1:0] m_set = '0;
   int           m_gate = 0;
   bit           m_run = 1'b0;
   int           m_err_exp = 0;
   int           m_strobe_exp = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] m_entry();
      logic [W-1:0] v = '0;
      foreach (mq[i]) v = (v << 4) | W'(mq[i]);
      return v;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_set  = '0;
      m_gate = 0;
      m_run  = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_step(input int code);
      m_err_exp    = 0;
      m_strobe_exp = 0;
      if (code <= 9) begin
         if (mq.size() < DIGITS) mq.push_back(code);
         else m_err_exp = 1;
      end else if (code == 10) begin
         if (mq.size() > 0) begin
            m_set = m_entry();
            exp_q.push_back(m_set);
            m_strobe_exp = 1;
            mq.delete();
         end else m_err_exp = 1;
      end else if (code == 11) begin
         if (mq.size() > 0) void'(mq.pop_back());
         else m_err_exp = 1;
      end else if (code == 12) begin
         mq.delete();
      end else if (code == 13) begin
         m_gate = (m_gate + 1) % 4;
      end else if (code == 14) begin
         m_run = ~m_run;
      end else begin
         mq.delete();
         m_run = 1'b0;
      end
   endtask

   // Pulse counters; a pulse longer than one cycle inflates the count.
   always @(negedge clk) begin
      if (reset) begin
         if (key_event) n_event++;
         if (err) n_err++;
         if (set_strobe) begin
            n_strobe++;
            check("strobe_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("strobe_set_bcd", set_bcd, exp_q.pop_front());
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_entry_bcd"}, entry_bcd, m_entry());
      check({tag, "_entry_len"}, entry_len, mq.size());
      check({tag, "_set_bcd"}, set_bcd, m_set);
      check({tag, "_gate_sel"}, gate_sel, m_gate);
      check({tag, "_run"}, run, m_run);
   endtask

   task automatic check_pulses(input string tag, input int e0, input int r0, input int s0,
                               input int ev_exp);
      check({tag, "_key_event"}, n_event - e0, ev_exp);
      check({tag, "_err"}, n_err - r0, ev_exp != 0 ? m_err_exp : 0);
      check({tag, "_set_strobe"}, n_strobe - s0, ev_exp != 0 ? m_strobe_exp : 0);
   endtask

   task automatic press(input string tag, input int code, input int hold, input int rel);
      int e0, r0, s0;
      e0 = n_event; r0 = n_err; s0 = n_strobe;
      model_step(code);
      key_value = 4'(code);
      key_valid = 1'b1;
      cyc(hold);
      key_valid = 1'b0;
      cyc(rel);
      check_pulses(tag, e0, r0, s0, 1);
      check_state(tag);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_entry_bcd"}, entry_bcd, 0);
      check({tag, "_entry_len"}, entry_len, 0);
      check({tag, "_set_bcd"}, set_bcd, 0);
      check({tag, "_outs"}, {set_strobe, gate_sel, run, key_event, err}, 0);
   endtask

   initial begin
      int e0, r0, s0, code, hold, rel;
      model_reset();
      cyc(3);
      check_zero("reset");
      reset = 1'b1;
      cyc(2);

      // Entry and commit
      press("d1", 1, 10, 12);
      press("d2", 2, 10, 12);
      press("d3", 3, 10, 12);
      press("d4", 4, 10, 12);
      press("enter", 10, 10, 12);
      check("commit_1234", set_bcd, 32'h1234);

      // Overflow on the fifth digit
      press("d5", 5, 10, 12);
      press("d6", 6, 10, 12);
      press("d7", 7, 10, 12);
      press("d8", 8, 10, 12);
      press("d9_full", 9, 10, 12);
      check("full_5678", entry_bcd, 32'h5678);
      press("clr", 12, 10, 12);

      // Short glitch must not execute
      e0 = n_event; r0 = n_err; s0 = n_strobe;
      key_value = 4'h2;
      key_valid = 1'b1;
      cyc(3);
      key_valid = 1'b0;
      cyc(12);
      check_pulses("glitch", e0, r0, s0, 0);
      check_state("glitch");

      // Code change mid-press: only the final code runs
      e0 = n_event; r0 = n_err; s0 = n_strobe;
      model_step(7);
      key_value = 4'h3;
      key_valid = 1'b1;
      cyc(2);
      key_value = 4'h7;
      cyc(12);
      key_valid = 1'b0;
      cyc(12);
      check_pulses("chg37", e0, r0, s0, 1);
      check_state("chg37");

      for (int i = 0; i < 4; i++) press("gate", 13, 10, 12);
      press("run_hold", 14, 50, 12);
      press("clr2", 12, 10, 12);
      press("bksp_empty", 11, 10, 12);
      press("enter_empty", 10, 10, 12);
      press("gate1", 13, 10, 12);
      press("d9", 9, 10, 12);

      // Reset mid-press with the key still held afterwards
      e0 = n_event; r0 = n_err; s0 = n_strobe;
      key_value = 4'h1;
      key_valid = 1'b1;
      cyc(5);
      reset = 1'b0;
      cyc(2);
      check_zero("mid_reset");
      model_reset();
      reset = 1'b1;
      model_step(1);
      cyc(15);
      key_valid = 1'b0;
      cyc(12);
      check_pulses("post_reset", e0, r0, s0, 1);
      check_state("post_reset");

      for (int i = 0; i < 40; i++) begin
         code = $urandom_range(0, 15);
         hold = $urandom_range(8, 20);
         rel  = $urandom_range(12, 20);
         press($sformatf("rnd%0d_k%0h", i, code), code, hold, rel);
      end

      check("strobes_all_seen", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
